// File: rtl/ps2_host_rx.sv
// PS/2 device-to-host receiver: line conditioning, 11-bit frame check, E0/F0 scancode decode.
// Optional 8-entry receive FIFO when PS2_HOST_RX_FIFO_EN is defined.
module ps2_host_rx #(
  parameter int FILTER_LEN = 4,
  parameter int TIMEOUT    = 1024
) (
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
`ifdef PS2_HOST_RX_FIFO_EN
  input  logic       rx_rd,
  output logic       rx_empty,
  output logic       rx_overflow,
`endif
  output logic [7:0] rx_byte,
  output logic       rx_strobe,
  output logic       rx_err,
  output logic [1:0] err_code,
  output logic       busy,
  output logic [7:0] key_code,
  output logic       key_pressed,
  output logic       key_extended,
  output logic       key_strobe
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  // Bit 0 carries the clock line, bit 1 the data line.
  logic [1:0]      sync1_q, sync2_q;
  logic [1:0]      filt_q, filt_d;
  logic [1:0][3:0] fcnt_q, fcnt_d;
  logic            fclk_prev_q;
  logic            fe, din;

  state_t          state_q, state_d;
  logic [2:0]      bcnt_q, bcnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TW-1:0]   tcnt_q, tcnt_d;
  logic            good, perr, ferr, tout;

  logic            rx_strobe_q, rx_strobe_d;
  logic            rx_err_q, rx_err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [7:0]      key_code_q, key_code_d;
  logic            key_pressed_q, key_pressed_d;
  logic            key_extended_q, key_extended_d;
  logic            key_strobe_q, key_strobe_d;
  logic            ext_q, ext_d;
  logic            rel_q, rel_d;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      sync1_q     <= 2'b11;
      sync2_q     <= 2'b11;
      filt_q      <= 2'b11;
      fcnt_q      <= '0;
      fclk_prev_q <= 1'b1;
    end else begin
      sync1_q     <= {ps2_data, ps2_clk};
      sync2_q     <= sync1_q;
      filt_q      <= filt_d;
      fcnt_q      <= fcnt_d;
      fclk_prev_q <= filt_q[0];
    end
  end

  // A line flips only after FILTER_LEN consecutive samples disagree with it.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = fcnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (fcnt_q[i] == 4'(FILTER_LEN - 1)) begin
          filt_d[i] = sync2_q[i];
          fcnt_d[i] = '0;
        end else begin
          fcnt_d[i] = fcnt_q[i] + 4'd1;
        end
      end else begin
        fcnt_d[i] = '0;
      end
    end
  end

  assign fe   = fclk_prev_q & ~filt_q[0];
  assign din  = filt_q[1];
  assign busy = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    shift_d = shift_q;
    par_d   = par_q;
    good    = 1'b0;
    perr    = 1'b0;
    ferr    = 1'b0;
    tout    = 1'b0;
    tcnt_d  = (state_q == IDLE || fe) ? '0 : tcnt_q + TW'(1);
    case (state_q)
      IDLE: if (fe && !din) begin
        state_d = DATA;
        bcnt_d  = '0;
      end
      DATA: if (fe) begin
        shift_d = {din, shift_q[7:1]};
        bcnt_d  = bcnt_q + 3'd1;
        if (bcnt_q == 3'd7) state_d = PARITY;
      end
      PARITY: if (fe) begin
        par_d   = din;
        state_d = STOP;
      end
      STOP: if (fe) begin
        state_d = IDLE;
        if (!din)                  ferr = 1'b1;
        else if (^{shift_q, par_q}) good = 1'b1;
        else                       perr = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // A falling edge in the timeout cycle keeps the frame alive.
    if (state_q != IDLE && !fe && tcnt_q == TW'(TIMEOUT)) begin
      tout    = 1'b1;
      state_d = IDLE;
    end
  end

  always_comb begin
    rx_strobe_d    = good;
    rx_err_d       = perr | ferr | tout;
    err_code_d     = ferr ? 2'b10 : perr ? 2'b01 : tout ? 2'b11 : err_code_q;
    key_strobe_d   = 1'b0;
    key_code_d     = key_code_q;
    key_pressed_d  = key_pressed_q;
    key_extended_d = key_extended_q;
    ext_d          = ext_q;
    rel_d          = rel_q;
    if (rx_err_d) begin
      ext_d = 1'b0;
      rel_d = 1'b0;
    end else if (good) begin
      if (shift_q == 8'hE0) begin
        ext_d = 1'b1;
      end else if (shift_q == 8'hF0) begin
        rel_d = 1'b1;
      end else begin
        key_strobe_d   = 1'b1;
        key_code_d     = shift_q;
        key_pressed_d  = ~rel_q;
        key_extended_d = ext_q;
        ext_d          = 1'b0;
        rel_d          = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      bcnt_q         <= '0;
      shift_q        <= '0;
      par_q          <= 1'b0;
      tcnt_q         <= '0;
      rx_strobe_q    <= 1'b0;
      rx_err_q       <= 1'b0;
      err_code_q     <= 2'b00;
      key_code_q     <= '0;
      key_pressed_q  <= 1'b0;
      key_extended_q <= 1'b0;
      key_strobe_q   <= 1'b0;
      ext_q          <= 1'b0;
      rel_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      bcnt_q         <= bcnt_d;
      shift_q        <= shift_d;
      par_q          <= par_d;
      tcnt_q         <= tcnt_d;
      rx_strobe_q    <= rx_strobe_d;
      rx_err_q       <= rx_err_d;
      err_code_q     <= err_code_d;
      key_code_q     <= key_code_d;
      key_pressed_q  <= key_pressed_d;
      key_extended_q <= key_extended_d;
      key_strobe_q   <= key_strobe_d;
      ext_q          <= ext_d;
      rel_q          <= rel_d;
    end
  end

  assign rx_strobe    = rx_strobe_q;
  assign rx_err       = rx_err_q;
  assign err_code     = err_code_q;
  assign key_code     = key_code_q;
  assign key_pressed  = key_pressed_q;
  assign key_extended = key_extended_q;
  assign key_strobe   = key_strobe_q;

`ifdef PS2_HOST_RX_FIFO_EN
  logic [7:0] mem_q [8];
  logic [7:0] mem_d [8];
  logic [2:0] wp_q, wp_d, rp_q, rp_d;
  logic [3:0] cnt_q, cnt_d;
  logic       ovf_q, ovf_d;
  logic       pop, wr_en;

  // A full FIFO still accepts a push when a pop frees a slot on the same edge.
  always_comb begin
    mem_d = mem_q;
    pop   = rx_rd && (cnt_q != 4'd0);
    wr_en = good && ((cnt_q != 4'd8) || pop);
    wp_d  = wp_q;
    rp_d  = rp_q;
    ovf_d = ovf_q | (good & ~wr_en);
    if (wr_en) begin
      mem_d[wp_q] = shift_q;
      wp_d        = wp_q + 3'd1;
    end
    if (pop) rp_d = rp_q + 3'd1;
    cnt_d = cnt_q + {3'b000, wr_en} - {3'b000, pop};
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mem_q[i] <= '0;
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      mem_q <= mem_d;
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  assign rx_byte     = mem_q[rp_q];
  assign rx_empty    = (cnt_q == 4'd0);
  assign rx_overflow = ovf_q;
`else
  logic [7:0] rx_byte_q, rx_byte_d;

  always_comb begin
    rx_byte_d = good ? shift_q : rx_byte_q;
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) rx_byte_q <= '0;
    else       rx_byte_q <= rx_byte_d;
  end

  assign rx_byte = rx_byte_q;
`endif

endmodule

// File: tb/tb_ps2_host_rx.sv
// Directed bench for ps2_host_rx: frames, decoder prefixes, errors, timeout, glitch, mid-frame reset.
module tb_ps2_host_rx;

  localparam int HALF    = 20;
  localparam int TIMEOUT = 1024;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] rx_byte;
  logic       rx_strobe, rx_err, busy;
  logic [1:0] err_code;
  logic [7:0] key_code;
  logic       key_pressed, key_extended, key_strobe;
`ifdef PS2_HOST_RX_FIFO_EN
  logic       rx_rd = 1'b0;
  logic       rx_empty, rx_overflow;
`endif

  ps2_host_rx #(.FILTER_LEN(4), .TIMEOUT(TIMEOUT)) dut (
    .clk_sys(clk), .reset(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
`ifdef PS2_HOST_RX_FIFO_EN
    .rx_rd(rx_rd), .rx_empty(rx_empty), .rx_overflow(rx_overflow),
`endif
    .rx_byte(rx_byte), .rx_strobe(rx_strobe), .rx_err(rx_err), .err_code(err_code),
    .busy(busy), .key_code(key_code), .key_pressed(key_pressed),
    .key_extended(key_extended), .key_strobe(key_strobe)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Event monitor: counts strobes and captures outputs on the opposite edge.
  int         n_rx = 0, n_err = 0, n_key = 0, n_key_alone = 0;
  logic [7:0] cap_rx = '0, cap_kc = '0;
  logic       cap_kp = 1'b0, cap_ke = 1'b0;
  logic [1:0] cap_ec = '0;

  always @(negedge clk) begin
    if (rx_strobe) begin n_rx++; cap_rx = rx_byte; end
    if (rx_err) begin n_err++; cap_ec = err_code; end
    if (key_strobe) begin
      n_key++;
      cap_kc = key_code; cap_kp = key_pressed; cap_ke = key_extended;
      if (!rx_strobe) n_key_alone++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    ps2_data = v;
    cycles(HALF);
    ps2_clk = 1'b0;
    cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  // Sends the first nbits of a frame (11 = complete frame).
  task automatic send(input logic [7:0] b, input logic bad_par, input logic stop, input int nbits);
    logic [10:0] f;
    f = {stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) drive_bit(f[i]);
    ps2_data = 1'b1;
    cycles(2 * HALF);
  endtask

  task automatic drain();
`ifdef PS2_HOST_RX_FIFO_EN
    for (int i = 0; i < 16; i++) begin
      if (!rx_empty) begin
        rx_rd = 1'b1; cycles(1); rx_rd = 1'b0;
      end
    end
`endif
  endtask

  initial begin
    int r0, e0, k0;

    // Reset state
    cycles(3);
    chk("reset_outputs_in_reset",
        {9'b0, rx_byte, rx_strobe, rx_err, err_code, busy, key_code, key_pressed, key_extended, key_strobe}, 32'h0);
    rst = 1'b0;
    cycles(5);
    chk("reset_outputs_after",
        {9'b0, rx_byte, rx_strobe, rx_err, err_code, busy, key_code, key_pressed, key_extended, key_strobe}, 32'h0);

    // Plain make code 1C
    r0 = n_rx; e0 = n_err; k0 = n_key;
    send(8'h1C, 1'b0, 1'b1, 11);
    chk("1c_rx_count", n_rx - r0, 1);
    chk("1c_rx_byte", cap_rx, 8'h1C);
    chk("1c_err_count", n_err - e0, 0);
    chk("1c_key", {n_key - k0, 24'(cap_kc), 7'b0, cap_kp, 7'b0, cap_ke}, {32'd1, 24'h1C, 8'h01, 8'h00});
`ifndef PS2_HOST_RX_FIFO_EN
    chk("1c_rx_byte_held", rx_byte, 8'h1C);
`endif
    chk("1c_busy_idle", busy, 1'b0);
    drain();

    // E0 F0 75: only the last byte produces a key event
    k0 = n_key; r0 = n_rx;
    send(8'hE0, 1'b0, 1'b1, 11); drain();
    chk("e0_no_key", n_key - k0, 0);
    send(8'hF0, 1'b0, 1'b1, 11); drain();
    chk("f0_no_key", n_key - k0, 0);
    send(8'h75, 1'b0, 1'b1, 11);
    chk("75_rx_count", n_rx - r0, 3);
    chk("75_rx_byte", cap_rx, 8'h75);
    chk("75_key_count", n_key - k0, 1);
    chk("75_key_fields", {cap_kc, cap_kp, cap_ke}, {8'h75, 1'b0, 1'b1});
    drain();

    // Prefixes followed by a parity error are forgotten
    r0 = n_rx; e0 = n_err; k0 = n_key;
    send(8'hE0, 1'b0, 1'b1, 11); drain();
    send(8'hF0, 1'b0, 1'b1, 11); drain();
    send(8'h1C, 1'b1, 1'b1, 11);
    chk("par_err_count", n_err - e0, 1);
    chk("par_err_code", cap_ec, 2'b01);
    chk("par_no_strobe", n_rx - r0, 2);
    send(8'h29, 1'b0, 1'b1, 11);
    chk("29_rx_byte", cap_rx, 8'h29);
    chk("29_key_fields", {n_key - k0, 24'(cap_kc), 7'b0, cap_kp, 7'b0, cap_ke}, {32'd1, 24'h29, 8'h01, 8'h00});
    drain();

    // Clock stalls after 5 bits
    r0 = n_rx; e0 = n_err;
    send(8'h29, 1'b0, 1'b1, 5);
    chk("stall_busy", busy, 1'b1);
    cycles(TIMEOUT + 10);
    chk("timeout_err_count", n_err - e0, 1);
    chk("timeout_err_code", cap_ec, 2'b11);
    chk("timeout_busy", busy, 1'b0);
    send(8'h29, 1'b0, 1'b1, 11);
    chk("after_timeout_rx", {n_rx - r0, 24'(cap_rx)}, {32'd1, 24'h29});
    drain();

    // Short clock glitch with data low, and a clean fe with data high, in IDLE
    r0 = n_rx; e0 = n_err;
    ps2_data = 1'b0; cycles(10);
    ps2_clk = 1'b0; cycles(2); ps2_clk = 1'b1;
    cycles(2);
    chk("glitch_busy_early", busy, 1'b0);
    cycles(20);
    ps2_data = 1'b1;
    chk("glitch_busy", busy, 1'b0);
    cycles(10);
    ps2_clk = 1'b0; cycles(HALF); ps2_clk = 1'b1; cycles(HALF);
    chk("idle_fe_data1_busy", busy, 1'b0);
    chk("idle_events", {n_rx - r0, n_err - e0}, 64'h0);

    // Framing errors, including framing taking priority over parity
    e0 = n_err; r0 = n_rx;
    send(8'h5A, 1'b0, 1'b0, 11);
    chk("frame_err_code", {n_err - e0, 30'b0, cap_ec}, {32'd1, 32'd2});
    send(8'h5A, 1'b1, 1'b0, 11);
    chk("frame_par_err_code", {n_err - e0, 30'b0, cap_ec}, {32'd2, 32'd2});
    chk("frame_no_strobe", n_rx - r0, 0);

    // Reset in the middle of a frame
    r0 = n_rx; e0 = n_err; k0 = n_key;
    send(8'h33, 1'b0, 1'b1, 4);
    chk("midframe_busy", busy, 1'b1);
    rst = 1'b1; cycles(3);
    chk("midframe_reset_busy", busy, 1'b0);
    rst = 1'b0; cycles(3 * HALF);
    chk("midframe_no_events", {n_rx - r0, n_err - e0}, 64'h0);
    chk("midframe_outputs", {rx_byte, err_code, key_code}, 18'h0);

    // Extended make after reset
    send(8'hE0, 1'b0, 1'b1, 11); drain();
    send(8'h1C, 1'b0, 1'b1, 11);
    chk("e0_1c_key", {n_key - k0, 24'(cap_kc), 7'b0, cap_kp, 7'b0, cap_ke}, {32'd1, 24'h1C, 8'h01, 8'h01});
    drain();
    chk("key_strobe_aligned", n_key_alone, 0);

`ifdef PS2_HOST_RX_FIFO_EN
    // Nine frames without popping overflow the 8-entry FIFO
    for (int i = 1; i <= 9; i++) send(8'(i), 1'b0, 1'b1, 11);
    chk("fifo_overflow", rx_overflow, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("fifo_pop_%0d", i), {rx_empty, rx_byte}, {1'b0, 8'(i)});
      rx_rd = 1'b1; cycles(1); rx_rd = 1'b0;
    end
    chk("fifo_empty", rx_empty, 1'b1);
    chk("fifo_overflow_sticky", rx_overflow, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ps2_host_rx.md
Name: ps2_host_rx

Overview:
- Core-side PS/2 host receiver for the keyboard/mouse lines driven by the MiST user_io PS/2 emulation (ps2_kbd_clk/ps2_kbd_data, ps2_mouse_clk/ps2_mouse_data).
- Deserialises 11-bit device-to-host frames into bytes and checks them.
- Keyboard bytes are further decoded (E0/F0 prefixes) into key_code/key_pressed/key_extended/key_strobe events.
- One instance per PS/2 channel; runs entirely in clk_sys.

Parameters:
- FILTER_LEN, 4: clk_sys cycles a synchronised line must hold a new level before it is accepted (glitch filter); legal range 1..15.
- TIMEOUT, 1024: clk_sys cycles without a filtered ps2_clk falling edge mid-frame before the frame is aborted; must exceed one bit period, i.e. 2*(PS2DIV+1).

Ports:
- clk_sys  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ps2_clk  in  1  PS/2 clock from the device; idle high
- ps2_data  in  1  PS/2 data from the device; idle high
- rx_byte  out  8  last received byte; held until the next good byte
- rx_strobe  out  1  one-cycle pulse: rx_byte is valid
- rx_err  out  1  one-cycle pulse: frame rejected
- err_code  out  2  cause of the last rx_err: 01 parity, 10 start/stop framing, 11 timeout; held until the next error
- busy  out  1  high while a frame is in progress
- key_code  out  8  decoded scan code
- key_pressed  out  1  1 = make, 0 = break
- key_extended  out  1  code was preceded by E0
- key_strobe  out  1  one-cycle pulse: key_* outputs are valid

Behaviour:
- Reset:
  - All outputs are 0.
  - State is IDLE; prefix flags are clear; filters preload 1.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-flop synchroniser, then a filter.
  - The filter output changes only after FILTER_LEN consecutive equal samples that differ from its current value.
  - Falling edge (fe) = filtered clk was 1 last cycle and is 0 this cycle.
  - Data is sampled from the filtered data in the fe cycle.
- Frame format, one bit per fe:
  - start 0
  - d0..d7, LSB first
  - parity: odd (d0..d7 plus parity has an odd count of ones)
  - stop 1
- State machine:
  - IDLE -> DATA on fe with data = 0. An fe with data = 1 in IDLE is ignored and raises no error.
  - DATA: shift 8 bits, bit counter 0..7, then go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP on fe:
    - data = 1 and parity OK: rx_byte/rx_strobe registered the cycle after the stop-bit fe.
    - data = 1 and parity bad: rx_err with err_code 01.
    - data = 0: rx_err with err_code 10. Framing takes priority over parity.
    - Every STOP outcome returns to IDLE.
  - busy = 1 in DATA, PARITY and STOP.
- Timeout:
  - Counter clears on every fe and counts while busy.
  - When it reaches TIMEOUT: rx_err with err_code 11, return to IDLE.
  - An fe in the same cycle as the timeout wins: the bit is accepted and the counter clears.
- Scancode decoder:
  - Runs on each rx_strobe.
  - E0: set ext, no key_strobe.
  - F0: set rel, no key_strobe.
  - Any other byte: key_code = byte, key_pressed = !rel, key_extended = ext, key_strobe pulses in the same cycle as rx_strobe; then clear ext and rel.
  - rx_err clears ext and rel.
  - Strobes never overlap across consecutive frames; the minimum frame spacing far exceeds 2 cycles.
- Reset mid-frame: the frame is discarded immediately and no strobe or error is emitted.

Optional Feature:
- Macro PS2_HOST_RX_FIFO_EN.
- Defined:
  - 8-entry byte FIFO after frame checking.
  - Extra ports: rx_rd (in, 1), rx_empty (out, 1), rx_overflow (out, 1, sticky until reset).
  - rx_byte shows the FIFO head; rx_rd while !rx_empty pops on the next edge.
  - A push when full drops the new byte and sets rx_overflow.
  - Simultaneous push and pop when full is legal: no drop.
  - rx_strobe still pulses once per received byte.
  - The decoder consumes bytes at push time, so it is unaffected by the FIFO.
- Undefined: no FIFO and no extra ports; rx_byte is a holding register.

Test Plan:
- Frame 0x1C (bits 0,0,0,1,1,1,0,0,0, parity 0, stop 1) -> rx_strobe, rx_byte=1C; key_code=1C, key_pressed=1, key_extended=0.
- Frames E0, F0, 75 -> a single key_strobe after 75 only, with key_code=75, key_pressed=0, key_extended=1.
- Frame 0x1C with parity bit 1 -> rx_err, err_code=01, no rx_strobe. Then frame 0x29 -> rx_byte=29 and decoder flags clear.
- Clock stopped after 5 bits for TIMEOUT+10 cycles -> rx_err, err_code=11, busy=0. Next full 0x29 frame is received correctly.
- 2-cycle low glitch on ps2_clk in IDLE with FILTER_LEN=4 -> no state change, busy stays 0. Stop bit 0 -> err_code=10.
- With PS2_HOST_RX_FIFO_EN: 9 frames and no rx_rd -> rx_overflow=1. Popping 8 times returns the first 8 bytes in order, then rx_empty=1.
